ula_mdu: RTL and testbench
==========================

// Module: ula_mdu
// PURPOSE
//  Iterative multiply/divide unit for the RV32M extension; the sequential companion to the combinational ALU.
//  Sits beside the ALU in the execute stage. Control stalls the PC while busy=1 and writes result
//  to the register file on the done pulse. Width is parametrised; one result bit is produced per cycle.
// PARAMETERS
//  XLEN   32  operand/result width (>=8, even)
//  OPW    5   opcode width, shared with the ALU op encoding
// PORTS
//  clk     in   1     clock, all state changes on posedge
//  rst     in   1     synchronous, active-high reset
//  start   in   1     request; accepted only when ready=1
//  op      in   OPW   operation, sampled with start
//  a       in   XLEN  rs1 operand, sampled with start
//  b       in   XLEN  rs2 operand, sampled with start
//  kill    in   1     abort in-flight op (pipeline flush)
//  ready   out  1     unit idle, start will be accepted
//  busy    out  1     operation in flight (= ~ready)
//  done    out  1     one-cycle pulse, result valid
//  result  out  XLEN  result; held from done until next accepted start
//  dz      out  1     last op was DIV/DIVU/REM/REMU with b==0; held like result
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, ready=1, busy=0, done=0, result=0, dz=0. Takes priority over kill/start.
//  - Op codes (OPW=5): MUL 01000, MULH 01001, MULHSU 01010, MULHU 01011,
//    DIV 01100, DIVU 01101, REM 01110, REMU 01111. Any other code: result=0, fast path.
//  - States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//    IDLE: start&ready -> latch op,a,b; operands converted to magnitudes per signedness; sign flags latched.
//      Normal ops go to CALC with cnt=XLEN-1. Fast-path cases go straight to FIX.
//    CALC: multiply = shift-add over a 2*XLEN product; divide = restoring shift-subtract
//      (1 quotient bit per cycle). cnt decrements; cnt==0 -> FIX.
//    FIX: apply sign correction (negate product/quotient/remainder). Select the low/high product half
//      or quotient/remainder. Register result and dz.
//    DONE: done=1 for exactly this cycle -> IDLE.
//  - Latency: start accepted at edge N -> done=1 in cycle N+XLEN+2 (normal).
//    Fast path -> done in cycle N+2. Throughput: a new start may be accepted in the cycle after DONE.
//    ready is low during DONE.
//  - Fast path, RISC-V defined results, no trap:
//    b==0 DIV/DIVU -> all ones; REM/REMU -> a; dz=1.
//    Signed overflow a==MIN, b==-1: DIV -> MIN, REM -> 0.
//  - Signedness: MULH s*s, MULHSU s*u, MULHU u*u; MUL is the low XLEN bits, identical for all.
//    Remainder takes the dividend's sign.
//  - start while busy: ignored, no queueing; op/a/b changes during busy have no effect.
//  - kill (rst=0): from any non-IDLE state -> IDLE at next edge.
//    No done pulse; result/dz keep prior values. kill in IDLE is a no-op.
//    kill and start in the same IDLE cycle: kill wins, start dropped.
//  - Only registered outputs; no combinational path from inputs to done/result.
// STRUCTURE
//  - ula_pkg: localparams for all ULA/MDU op codes (shared with the ALU); typedef enum mdu_state_t {IDLE,CALC,FIX,DONE}.
//  - One sub-module, mdu_negate #(XLEN): conditional two's-complement, used for operand magnitude and result sign fix.
//  - Counter width $clog2(XLEN); no other sub-modules.
// TESTING
//  1 MUL a=7, b=-3 (XLEN=32) -> done at N+34, result=32'hFFFFFFEB; MULHU 32'hFFFFFFFF^2 -> 32'hFFFFFFFE.
//  2 MULH a=32'h80000000, b=2 -> 32'hFFFFFFFF. MULHSU a=-1, b=32'hFFFFFFFF -> 32'hFFFFFFFF.
//  3 DIV -7/2 -> 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4 DIV 5/0 -> done at N+2, result=32'hFFFFFFFF, dz=1; REM 5/0 -> 5, dz=1.
//    DIV 32'h80000000/-1 -> 32'h80000000, dz=0.
//  5 Start a DIV, pulse kill at N+10 -> ready=1 at N+11, no done pulse, result keeps old value.
//    A start pulsed during busy is ignored.
//    Repeat with rst at N+10 -> all outputs 0.
//  6 Back-to-back: second start in the cycle after done -> accepted, correct second result.
//    Random signed/unsigned sweep vs reference model, XLEN=32 and XLEN=16.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: shared ULA/MDU op codes and multiply/divide state encoding
package ula_pkg;
  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b01001;
  localparam logic [4:0] OP_MULHSU = 5'b01010;
  localparam logic [4:0] OP_MULHU  = 5'b01011;
  localparam logic [4:0] OP_DIV    = 5'b01100;
  localparam logic [4:0] OP_DIVU   = 5'b01101;
  localparam logic [4:0] OP_REM    = 5'b01110;
  localparam logic [4:0] OP_REMU   = 5'b01111;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_t;
endpackage

// File: rtl/mdu_negate.sv
// mdu_negate: conditional two's-complement negation
module mdu_negate #(
  parameter int XLEN = 32
) (
  input  logic            neg,
  input  logic [XLEN-1:0] x,
  output logic [XLEN-1:0] y
);
  assign y = neg ? -x : x;
endmodule

// File: rtl/ula_mdu.sv
// ula_mdu: iterative RV32M multiply/divide unit, one result bit per cycle
module ula_mdu
  import ula_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            dz
);
  localparam int CW = $clog2(XLEN);
  mdu_state_t state_q, state_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic div_q, div_d, selhi_q, selhi_d, negr_q, negr_d, dzp_q, dzp_d, dz_q, dz_d, done_q, done_d;
  logic o_mul, o_mulh, o_mulhsu, o_mulhu, o_div, o_divu, o_rem, o_remu;
  logic ml, dv, sa, sb, bz, ovf, fast;
  logic [XLEN-1:0] ma, mb, fast_val;
  logic [XLEN:0] sum, sh, diff;
  logic [2*XLEN-1:0] fix_in, fix_out;
  assign o_mul    = op == OPW'(OP_MUL);
  assign o_mulh   = op == OPW'(OP_MULH);
  assign o_mulhsu = op == OPW'(OP_MULHSU);
  assign o_mulhu  = op == OPW'(OP_MULHU);
  assign o_div    = op == OPW'(OP_DIV);
  assign o_divu   = op == OPW'(OP_DIVU);
  assign o_rem    = op == OPW'(OP_REM);
  assign o_remu   = op == OPW'(OP_REMU);
  assign ml = o_mul | o_mulh | o_mulhsu | o_mulhu;
  assign dv = o_div | o_divu | o_rem | o_remu;
  assign sa = a[XLEN-1] & (o_mulh | o_mulhsu | o_div | o_rem);
  assign sb = b[XLEN-1] & (o_mulh | o_div | o_rem);
  assign bz = dv & (b == '0);
  assign ovf = (o_div | o_rem) & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
  assign fast = ~(ml | dv) | bz | ovf;
  assign fast_val = bz ? ((o_div | o_divu) ? '1 : a) : (ovf & o_div) ? a : '0;
  mdu_negate #(.XLEN(XLEN)) u_neg_a (.neg(sa), .x(a), .y(ma));
  mdu_negate #(.XLEN(XLEN)) u_neg_b (.neg(sb), .x(b), .y(mb));
  assign sum  = {1'b0, hi_q} + {1'b0, m_q};
  assign sh   = {hi_q, lo_q[XLEN-1]};
  assign diff = sh - {1'b0, m_q};
  assign fix_in = div_q ? {{XLEN{1'b0}}, selhi_q ? hi_q : lo_q} : {hi_q, lo_q};
  mdu_negate #(.XLEN(2*XLEN)) u_neg_r (.neg(negr_q), .x(fix_in), .y(fix_out));
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    selhi_d  = selhi_q;
    negr_d   = negr_q;
    dzp_d    = dzp_q;
    result_d = result_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        div_d   = dv | fast;
        selhi_d = ~fast & (o_mulh | o_mulhsu | o_mulhu | o_rem | o_remu);
        negr_d  = ~fast & ((o_rem | o_remu) ? sa : sa ^ sb);
        dzp_d   = bz;
        m_d     = dv ? mb : ma;
        hi_d    = '0;
        lo_d    = fast ? fast_val : dv ? ma : mb;
        cnt_d   = CW'(XLEN - 1);
        state_d = fast ? FIX : CALC;
      end
      CALC: begin
        {hi_d, lo_d} = div_q ? {diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0], lo_q[XLEN-2:0], ~diff[XLEN]}
                             : {lo_q[0] ? sum : {1'b0, hi_q}, lo_q[XLEN-1:1]};
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? FIX : CALC;
      end
      FIX: begin
        result_d = (~div_q & selhi_q) ? fix_out[2*XLEN-1:XLEN] : fix_out[XLEN-1:0];
        dz_d     = dzp_q;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d  = IDLE;
      result_d = result_q;
      dz_d     = dz_q;
      done_d   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      selhi_q  <= 1'b0;
      negr_q   <= 1'b0;
      dzp_q    <= 1'b0;
      result_q <= '0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      selhi_q  <= selhi_d;
      negr_q   <= negr_d;
      dzp_q    <= dzp_d;
      result_q <= result_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end
  assign ready  = state_q == IDLE;
  assign busy   = ~ready;
  assign done   = done_q;
  assign result = result_q;
  assign dz     = dz_q;
endmodule

// File: tb/tb_ula_mdu.sv
// tb_ula_mdu: directed vectors, abort/reset sequences and random sweep of ula_mdu at XLEN 32 and 16
module tb_ula_mdu;
  import ula_pkg::*;
  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, res;
    logic        dz;
    int          lat;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic start32 = 1'b0, kill32 = 1'b0;
  logic [4:0] op32 = '0;
  logic [31:0] a32 = '0, b32 = '0, res32;
  logic ready32, busy32, done32, dz32;
  logic start16 = 1'b0, kill16 = 1'b0;
  logic [4:0] op16 = '0;
  logic [15:0] a16 = '0, b16 = '0, res16;
  logic ready16, busy16, done16, dz16;
  ula_mdu #(.XLEN(32), .OPW(5)) u32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32), .kill(kill32),
    .ready(ready32), .busy(busy32), .done(done32), .result(res32), .dz(dz32)
  );
  ula_mdu #(.XLEN(16), .OPW(5)) u16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16), .kill(kill16),
    .ready(ready16), .busy(busy16), .done(done16), .result(res16), .dz(dz16)
  );
  int checks = 0, failures = 0;
  function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endfunction
  function automatic logic [31:0] refm(int w, logic [4:0] o, logic [31:0] x, logic [31:0] y,
                                       output logic dz, output logic fast);
    logic [31:0] m;
    logic signed [31:0] t;
    logic signed [127:0] xs, ys, xu, yu, mn;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    t = x << (32 - w);
    t = t >>> (32 - w);
    xs = t;
    t = y << (32 - w);
    t = t >>> (32 - w);
    ys = t;
    xu = {96'b0, x & m};
    yu = {96'b0, y & m};
    mn = -(128'sd1 << (w - 1));
    dz = 1'b0;
    fast = 1'b0;
    if (o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU} && yu == 0) begin
      dz = 1'b1;
      fast = 1'b1;
      return (o inside {OP_DIV, OP_DIVU}) ? m : (x & m);
    end
    if (o inside {OP_DIV, OP_REM} && xs == mn && ys == -128'sd1) begin
      fast = 1'b1;
      return (o == OP_DIV) ? (x & m) : 32'd0;
    end
    case (o)
      OP_MUL:    return 32'(xu * yu) & m;
      OP_MULH:   return 32'((xs * ys) >> w) & m;
      OP_MULHSU: return 32'((xs * yu) >> w) & m;
      OP_MULHU:  return 32'((xu * yu) >> w) & m;
      OP_DIV:    return 32'(xs / ys) & m;
      OP_DIVU:   return 32'(xu / yu) & m;
      OP_REM:    return 32'(xs % ys) & m;
      OP_REMU:   return 32'(xu % yu) & m;
      default: begin
        fast = 1'b1;
        return 32'd0;
      end
    endcase
  endfunction
  function automatic logic [31:0] rnd(int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return m;
      2: return (m >> 1) + 32'd1;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom & m;
    endcase
  endfunction
  task automatic go(input int w, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                    input int spur, output logic [31:0] r, output logic d, output int lat);
    @(negedge clk);
    if (w == 32) begin
      op32 = o; a32 = x; b32 = y; start32 = 1'b1;
    end else begin
      op16 = o; a16 = x[15:0]; b16 = y[15:0]; start16 = 1'b1;
    end
    @(posedge clk);
    #1;
    start32 = 1'b0;
    start16 = 1'b0;
    op32 = 5'($urandom); a32 = $urandom; b32 = $urandom;
    op16 = 5'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
    lat = -1;
    for (int k = 1; k <= w + 10; k++) begin
      @(negedge clk);
      start32 = 1'b0;
      start16 = 1'b0;
      if (k == spur) begin
        if (w == 32) start32 = 1'b1;
        else start16 = 1'b1;
      end
      if (w == 32 ? done32 : done16) begin
        lat = k;
        break;
      end
    end
    start32 = 1'b0;
    start16 = 1'b0;
    r = (w == 32) ? res32 : {16'b0, res16};
    d = (w == 32) ? dz32 : dz16;
  endtask
  vec_t tbl[16];
  logic [4:0] ops[10];
  logic [4:0] o;
  logic [31:0] x, y, e, r;
  logic ed, ef, d;
  int lat, seen, w;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0]  = '{OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 34};
    tbl[1]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34};
    tbl[2]  = '{OP_MULH,   32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 1'b0, 34};
    tbl[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 34};
    tbl[4]  = '{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 34};
    tbl[5]  = '{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 34};
    tbl[6]  = '{OP_DIVU,   32'd100,       32'd7,         32'd14,        1'b0, 34};
    tbl[7]  = '{OP_REMU,   32'd100,       32'd7,         32'd2,         1'b0, 34};
    tbl[8]  = '{OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 2};
    tbl[9]  = '{OP_REM,    32'd5,         32'd0,         32'd5,         1'b1, 2};
    tbl[10] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 2};
    tbl[11] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 2};
    tbl[12] = '{OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 2};
    tbl[13] = '{5'b00000,  32'd3,         32'd4,         32'd0,         1'b0, 2};
    tbl[14] = '{OP_MULH,   32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34};
    tbl[15] = '{OP_MUL,    32'h1234_5678, 32'd16,        32'h2345_6780, 1'b0, 34};
    ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, 5'b00011, 5'b11000};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset ready", 32'(ready32), 32'd1);
    chk("reset busy", 32'(busy32), 32'd0);
    chk("reset done", 32'(done32), 32'd0);
    chk("reset result", res32, 32'd0);
    chk("reset dz", 32'(dz32), 32'd0);
    chk("reset16 result", 32'(res16), 32'd0);
    for (int i = 0; i < 16; i++) begin
      go(32, tbl[i].op, tbl[i].a, tbl[i].b, 5, r, d, lat);
      chk($sformatf("vec%0d result", i), r, tbl[i].res);
      chk($sformatf("vec%0d dz", i), 32'(d), 32'(tbl[i].dz));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].lat));
    end
    go(32, OP_DIVU, 32'd100, 32'd7, 0, r, d, lat);
    chk("pre-kill result", r, 32'd14);
    @(negedge clk);
    op32 = OP_DIV; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (2) @(negedge clk);
    op32 = OP_MUL; a32 = 32'd2; b32 = 32'd3; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (7) @(negedge clk);
    chk("busy before kill", 32'(busy32), 32'd1);
    kill32 = 1'b1;
    @(negedge clk);
    kill32 = 1'b0;
    chk("kill ready", 32'(ready32), 32'd1);
    chk("kill busy", 32'(busy32), 32'd0);
    chk("kill result held", res32, 32'd14);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) seen++;
    end
    chk("kill no done", 32'(seen), 32'd0);
    chk("kill idle after", 32'(ready32), 32'd1);
    @(negedge clk);
    op32 = OP_DIVU; a32 = 32'd9; b32 = 32'd2; start32 = 1'b1; kill32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; kill32 = 1'b0;
    chk("kill+start ready", 32'(ready32), 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) seen++;
    end
    chk("kill+start no done", 32'(seen), 32'd0);
    chk("kill+start result held", res32, 32'd14);
    go(32, OP_DIV, 32'd5, 32'd0, 0, r, d, lat);
    chk("pre-rst dz", 32'(d), 32'd1);
    @(negedge clk);
    op32 = OP_DIVU; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst ready", 32'(ready32), 32'd1);
    chk("rst busy", 32'(busy32), 32'd0);
    chk("rst done", 32'(done32), 32'd0);
    chk("rst result", res32, 32'd0);
    chk("rst dz", 32'(dz32), 32'd0);
    for (int i = 0; i < 300; i++) begin
      w = (i < 150) ? 32 : 16;
      o = ops[$urandom_range(0, 9)];
      x = rnd(w);
      y = rnd(w);
      e = refm(w, o, x, y, ed, ef);
      go(w, o, x, y, (i % 3 == 0) ? 4 : 0, r, d, lat);
      chk($sformatf("rand%0d w%0d op%b a=%h b=%h result", i, w, o, x, y), r, e);
      chk($sformatf("rand%0d dz", i), 32'(d), 32'(ed));
      chk($sformatf("rand%0d latency", i), 32'(lat), ef ? 32'd2 : 32'(w + 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
